// File: rtl/lcd_text_pkg.sv
// Shared constants, FSM encodings and the text-row base-address helper for the
// LCD text-mode line fetch path.
package lcd_text_pkg;

    localparam int COLS      = 80;
    localparam int ROWS      = 30;
    localparam int GLYPH_H   = 16;
    localparam int LCD_WIDTH = 640;

    localparam logic [9:0] VIS_LINES = 10'(ROWS * GLYPH_H);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        SHIFT = 2'd2
    } main_state_t;

    typedef enum logic [1:0] {
        PF_IDLE = 2'd0,
        PF_FONT = 2'd1,
        PF_CAPT = 2'd2,
        PF_FULL = 2'd3
    } pf_state_t;

    // trow*80 computed as trow*64 + trow*16.
    function automatic logic [11:0] row_base(input logic [9:0] line_idx);
        return {line_idx[9:4], 6'b000000} + {2'b00, line_idx[9:4], 4'b0000};
    endfunction

endpackage

// File: rtl/glyph_shifter.sv
// Glyph row serialiser: an 8-bit shift register fed from a one-entry holding
// register, emitting bit 7 first.
module glyph_shifter (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       load,
    input  logic [7:0] glyph,
    input  logic       advance,
    output logic       pix,
    output logic       hold_v,
    output logic       consume,
    output logic       empty,
    output logic       last_bit
);

    logic [7:0] r_sreg;
    logic [7:0] r_hold;
    logic [2:0] r_cnt;
    logic       r_empty;
    logic       r_hold_v;

    // When empty, the first bit comes straight from the holding register so a
    // freshly captured glyph can be written without a bubble cycle.
    assign pix      = r_empty ? r_hold[7] : r_sreg[7];
    assign empty    = r_empty;
    assign hold_v   = r_hold_v;
    assign last_bit = !r_empty && (r_cnt == 3'd7);
    assign consume  = advance && r_hold_v && (r_empty || last_bit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sreg   <= 8'd0;
            r_hold   <= 8'd0;
            r_cnt    <= 3'd0;
            r_empty  <= 1'b1;
            r_hold_v <= 1'b0;
        end else if (flush) begin
            r_sreg   <= 8'd0;
            r_hold   <= 8'd0;
            r_cnt    <= 3'd0;
            r_empty  <= 1'b1;
            r_hold_v <= 1'b0;
        end else begin
            if (advance) begin
                if (r_empty) begin
                    r_sreg  <= {r_hold[6:0], 1'b0};
                    r_cnt   <= 3'd1;
                    r_empty <= 1'b0;
                end else if (r_cnt == 3'd7) begin
                    if (r_hold_v) begin
                        r_sreg <= r_hold;
                        r_cnt  <= 3'd0;
                    end else begin
                        r_empty <= 1'b1;
                    end
                end else begin
                    r_sreg <= {r_sreg[6:0], 1'b0};
                    r_cnt  <= r_cnt + 3'd1;
                end
            end
            if (load) begin
                r_hold   <= glyph;
                r_hold_v <= 1'b1;
            end else if (consume) begin
                r_hold_v <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/text_line_fetch_ctrl.sv
// Text-mode line scheduler: fetches character codes and glyph rows for each
// visible line, serialises them into pixels and shares the text RAM with a host.
module text_line_fetch_ctrl
    import lcd_text_pkg::*;
#(
    parameter logic [23:0] FG_COLOR = 24'hFFFFFF,
    parameter logic [23:0] BG_COLOR = 24'h000000
) (
    input  logic        pixel_clk,
    input  logic        rst,
    input  logic        line_start,
    input  logic [9:0]  line_idx,
    input  logic        fifo_full,
    output logic        px_wr,
    output logic [23:0] px_data,
    output logic        tr_en,
    output logic        tr_we,
    output logic [11:0] tr_addr,
    output logic [7:0]  tr_wdata,
    input  logic [7:0]  tr_rdata,
    output logic        fr_en,
    output logic [11:0] fr_addr,
    input  logic [7:0]  fr_rdata,
    input  logic        host_req,
    input  logic [11:0] host_addr,
    input  logic [7:0]  host_data,
    output logic        host_ack,
    output logic        line_done,
    output logic        line_overrun
);

    main_state_t r_state, w_state_nx;
    pf_state_t   r_pf, w_pf_nx;

    logic [11:0] r_row_base;
    logic [3:0]  r_line_lo;
    logic [6:0]  r_col;
    logic        r_col_pend;
    logic [9:0]  r_px_cnt;
    logic        r_line_done;
    logic        r_overrun;

    logic        w_ls;
    logic        w_ls_valid;
    logic        w_busy;
    logic        w_pf_issue;
    logic        w_fetch_tr;
    logic [11:0] w_fetch_addr;
    logic        w_grant;
    logic        w_px_wr;
    logic        w_last_px;
    logic        w_load;
    logic        w_pix;
    logic        w_hold_v;
    logic        w_consume;
    logic        w_empty;
    logic        w_last_bit;

    assign w_ls       = line_start && !rst;
    assign w_ls_valid = w_ls && (line_idx < VIS_LINES);
    assign w_busy     = (r_state != IDLE);

    // The first column is read in the line_start cycle itself, straight from the
    // incoming line index, so the first pixel lands three cycles later.
    assign w_pf_issue   = (r_pf == PF_IDLE) && w_busy && r_col_pend && !w_ls;
    assign w_fetch_tr   = w_ls_valid || w_pf_issue;
    assign w_fetch_addr = w_ls_valid ? row_base(line_idx) : (r_row_base + {5'd0, r_col});
    assign w_grant      = host_req && !rst && !w_fetch_tr;

    assign w_load    = (r_pf == PF_CAPT) && !w_ls;
    assign w_px_wr   = w_busy && !w_ls && !fifo_full && (w_hold_v || !w_empty);
    assign w_last_px = w_px_wr && (r_px_cnt == 10'(LCD_WIDTH - 1));

    glyph_shifter u_shifter (
        .clk      (pixel_clk),
        .rst      (rst),
        .flush    (w_ls),
        .load     (w_load),
        .glyph    (fr_rdata),
        .advance  (w_px_wr),
        .pix      (w_pix),
        .hold_v   (w_hold_v),
        .consume  (w_consume),
        .empty    (w_empty),
        .last_bit (w_last_bit)
    );

    always_comb begin
        w_state_nx = r_state;
        w_pf_nx    = r_pf;
        if (w_ls) begin
            w_state_nx = w_ls_valid ? PRIME : IDLE;
            w_pf_nx    = w_ls_valid ? PF_FONT : PF_IDLE;
        end else begin
            case (r_state)
                IDLE:    w_state_nx = IDLE;
                PRIME:   if (w_px_wr) w_state_nx = SHIFT;
                SHIFT:   if (w_last_px) w_state_nx = IDLE;
                default: w_state_nx = IDLE;
            endcase
            case (r_pf)
                PF_IDLE: if (w_pf_issue) w_pf_nx = PF_FONT;
                PF_FONT: w_pf_nx = PF_CAPT;
                PF_CAPT: w_pf_nx = PF_FULL;
                PF_FULL: if (w_consume) w_pf_nx = PF_IDLE;
                default: w_pf_nx = PF_IDLE;
            endcase
        end
    end

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_pf        <= PF_IDLE;
            r_row_base  <= 12'd0;
            r_line_lo   <= 4'd0;
            r_col       <= 7'd0;
            r_col_pend  <= 1'b0;
            r_px_cnt    <= 10'd0;
            r_line_done <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_pf        <= w_pf_nx;
            r_line_done <= w_last_px;
            r_overrun   <= w_ls && w_busy;
            if (w_ls) begin
                r_row_base <= row_base(line_idx);
                r_line_lo  <= line_idx[3:0];
                r_col      <= 7'd1;
                r_col_pend <= w_ls_valid;
                r_px_cnt   <= 10'd0;
            end else begin
                if (w_pf_issue) begin
                    r_col <= r_col + 7'd1;
                    if (r_col == 7'(COLS - 1)) r_col_pend <= 1'b0;
                end
                if (w_px_wr) r_px_cnt <= r_px_cnt + 10'd1;
            end
        end
    end

    always_comb begin
        tr_addr  = 12'd0;
        tr_wdata = 8'd0;
        if (w_fetch_tr) begin
            tr_addr = w_fetch_addr;
        end else if (w_grant) begin
            tr_addr  = host_addr;
            tr_wdata = host_data;
        end
    end

    assign tr_en        = w_fetch_tr || w_grant;
    assign tr_we        = w_grant;
    assign host_ack     = w_grant;
    assign fr_en        = (r_pf == PF_FONT) && !w_ls;
    assign fr_addr      = fr_en ? {tr_rdata, r_line_lo} : 12'd0;
    assign px_wr        = w_px_wr;
    assign px_data      = w_px_wr ? (w_pix ? FG_COLOR : BG_COLOR) : 24'd0;
    assign line_done    = r_line_done;
    assign line_overrun = r_overrun;

endmodule

// File: tb/tb_text_line_fetch_ctrl.sv
// Bench for text_line_fetch_ctrl: text RAM / font ROM models plus a per-line
// reference of the expected fetch addresses and pixel stream.
module tb_text_line_fetch_ctrl;

    logic        pixel_clk = 1'b0;
    logic        rst = 1'b1;
    logic        line_start = 1'b0;
    logic [9:0]  line_idx = 10'd0;
    logic        fifo_full = 1'b0;
    logic        host_req = 1'b0;
    logic [11:0] host_addr = 12'd0;
    logic [7:0]  host_data = 8'd0;
    logic        px_wr, tr_en, tr_we, fr_en, host_ack, line_done, line_overrun;
    logic [23:0] px_data;
    logic [11:0] tr_addr, fr_addr;
    logic [7:0]  tr_wdata, tr_rdata, fr_rdata;

    text_line_fetch_ctrl dut (
        .pixel_clk(pixel_clk), .rst(rst), .line_start(line_start), .line_idx(line_idx),
        .fifo_full(fifo_full), .px_wr(px_wr), .px_data(px_data), .tr_en(tr_en),
        .tr_we(tr_we), .tr_addr(tr_addr), .tr_wdata(tr_wdata), .tr_rdata(tr_rdata),
        .fr_en(fr_en), .fr_addr(fr_addr), .fr_rdata(fr_rdata), .host_req(host_req),
        .host_addr(host_addr), .host_data(host_data), .host_ack(host_ack),
        .line_done(line_done), .line_overrun(line_overrun)
    );

    always #5 pixel_clk = ~pixel_clk;

    logic [7:0] ram [4096];
    logic [7:0] rom [4096];

    always @(posedge pixel_clk) begin
        if (tr_en && tr_we) ram[tr_addr] <= tr_wdata;
        if (tr_en && !tr_we) tr_rdata <= ram[tr_addr];
        if (fr_en) fr_rdata <= rom[fr_addr];
    end

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int ls_cyc, first_px_cyc, done_cyc;
    int done_cnt, ovr_cnt, viol_cnt, ack_cnt;
    logic [23:0] cap_px[$];
    logic [11:0] cap_tr[$];
    logic [11:0] cap_fr[$];
    logic [23:0] exp_px[$];
    logic [11:0] exp_tr[$];
    logic [11:0] exp_fr[$];

    always @(negedge pixel_clk) begin
        cyc++;
        if (!rst) begin
            if (line_start) ls_cyc = cyc;
            if (px_wr) begin
                if (cap_px.size() == 0) first_px_cyc = cyc;
                cap_px.push_back(px_data);
                if (fifo_full) viol_cnt++;
            end
            if (tr_en && !tr_we) cap_tr.push_back(tr_addr);
            if (fr_en) cap_fr.push_back(fr_addr);
            if (line_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (line_overrun) ovr_cnt++;
            if (host_ack) ack_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_caps();
        cap_px.delete(); cap_tr.delete(); cap_fr.delete();
        done_cnt = 0; ovr_cnt = 0; viol_cnt = 0; ack_cnt = 0;
        first_px_cyc = -1; done_cyc = -1; ls_cyc = -1;
    endtask

    // Reference: for each column, code = RAM[trow*80+c], glyph = ROM[{code,line[3:0]}],
    // pixels are the glyph bits MSB first.
    task automatic build_exp(input logic [9:0] idx);
        exp_px.delete(); exp_tr.delete(); exp_fr.delete();
        for (int c = 0; c < 80; c++) begin
            int          a;
            logic [7:0]  code;
            logic [11:0] fa;
            logic [7:0]  g;
            a    = (int'(idx) / 16) * 80 + c;
            code = ram[a];
            fa   = {code, idx[3:0]};
            g    = rom[fa];
            exp_tr.push_back(12'(a));
            exp_fr.push_back(fa);
            for (int b = 7; b >= 0; b--) exp_px.push_back(g[b] ? 24'hFFFFFF : 24'h000000);
        end
    endtask

    task automatic start_line(input logic [9:0] idx);
        @(posedge pixel_clk); #1;
        clear_caps();
        line_start = 1'b1;
        line_idx   = idx;
        @(posedge pixel_clk); #1;
        line_start = 1'b0;
    endtask

    task automatic wait_px(input string tag, input int n);
        int i;
        for (i = 0; i < 2000 && cap_px.size() < n; i++) begin
            @(posedge pixel_clk); #1;
        end
        if (cap_px.size() < n) chk({tag, "/wait_px_timeout"}, cap_px.size(), n);
    endtask

    task automatic wait_done(input string tag);
        int i;
        for (i = 0; i < 3000 && done_cnt == 0; i++) begin
            @(posedge pixel_clk); #1;
        end
        chk({tag, "/line_done_seen"}, 32'(done_cnt != 0), 1);
        repeat (6) begin
            @(posedge pixel_clk); #1;
        end
    endtask

    task automatic check_line(input string tag, input int exp_done_lat);
        int bad, first_bad;
        chk({tag, "/px_count"}, cap_px.size(), 640);
        bad = 0; first_bad = -1;
        for (int i = 0; i < cap_px.size() && i < exp_px.size(); i++)
            if (cap_px[i] !== exp_px[i]) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
        chk({tag, "/px_mismatch_first_idx"}, first_bad, -1);
        chk({tag, "/tr_count"}, cap_tr.size(), 80);
        bad = 0;
        for (int i = 0; i < cap_tr.size() && i < 80; i++) if (cap_tr[i] !== exp_tr[i]) bad++;
        chk({tag, "/tr_addr_mismatches"}, bad, 0);
        chk({tag, "/fr_count"}, cap_fr.size(), 80);
        bad = 0;
        for (int i = 0; i < cap_fr.size() && i < 80; i++) if (cap_fr[i] !== exp_fr[i]) bad++;
        chk({tag, "/fr_addr_mismatches"}, bad, 0);
        chk({tag, "/line_done_count"}, done_cnt, 1);
        chk({tag, "/px_wr_while_full"}, viol_cnt, 0);
        if (exp_done_lat > 0) begin
            chk({tag, "/first_px_latency"}, first_px_cyc - ls_cyc, 3);
            chk({tag, "/line_done_latency"}, done_cyc - ls_cyc, exp_done_lat);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "/px_wr"}, px_wr, 0);
        chk({tag, "/px_data"}, px_data, 0);
        chk({tag, "/tr_en"}, tr_en, 0);
        chk({tag, "/tr_we"}, tr_we, 0);
        chk({tag, "/tr_addr"}, tr_addr, 0);
        chk({tag, "/tr_wdata"}, tr_wdata, 0);
        chk({tag, "/fr_en"}, fr_en, 0);
        chk({tag, "/fr_addr"}, fr_addr, 0);
        chk({tag, "/host_ack"}, host_ack, 0);
        chk({tag, "/line_done"}, line_done, 0);
        chk({tag, "/line_overrun"}, line_overrun, 0);
    endtask

    initial begin
        logic [9:0] idx, idx_b;
        int lat;
        for (int i = 0; i < 4096; i++) begin
            ram[i] = 8'($urandom);
            rom[i] = 8'($urandom);
        end
        clear_caps();
        repeat (3) @(posedge pixel_clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;
        repeat (2) @(posedge pixel_clk);

        // Uniform 'A' row on line 35.
        for (int c = 0; c < 80; c++) ram[160 + c] = 8'h41;
        build_exp(10'd35);
        start_line(10'd35);
        wait_done("s2");
        chk("s2/first_tr_addr", cap_tr.size() > 0 ? cap_tr[0] : 12'hFFF, 12'd160);
        chk("s2/first_fr_addr", cap_fr.size() > 0 ? cap_fr[0] : 12'hFFF, 12'h413);
        check_line("s2", 643);

        // Backpressure at px 7 and px 100, 5 cycles each.
        start_line(10'd35);
        wait_px("s3a", 7);
        fifo_full = 1'b1;
        repeat (5) begin
            @(posedge pixel_clk); #1;
        end
        fifo_full = 1'b0;
        wait_px("s3b", 100);
        fifo_full = 1'b1;
        repeat (5) begin
            @(posedge pixel_clk); #1;
        end
        fifo_full = 1'b0;
        wait_done("s3");
        check_line("s3", 653);

        // Host write mid-line on a row that does not contain address 5.
        ram[5] = 8'h00;
        idx = 10'($urandom_range(16, 479));
        build_exp(idx);
        start_line(idx);
        wait_px("s4", 200);
        host_req = 1'b1; host_addr = 12'd5; host_data = 8'h7A;
        lat = 0;
        #3;
        while (!host_ack && lat < 20) begin
            @(posedge pixel_clk); #4;
            lat++;
        end
        chk("s4/ack_latency_le8", 32'(lat <= 8), 1);
        chk("s4/ack_tr_we", tr_we, 1);
        chk("s4/ack_tr_addr", tr_addr, 12'd5);
        chk("s4/ack_tr_wdata", tr_wdata, 8'h7A);
        @(posedge pixel_clk); #1;
        host_req = 1'b0;
        wait_done("s4");
        check_line("s4", 0);
        chk("s4/ram5", ram[5], 8'h7A);
        chk("s4/ack_count", ack_cnt, 1);

        // Out-of-range line: no fetch activity, host served immediately.
        start_line(10'd480);
        repeat (10) begin
            @(posedge pixel_clk); #1;
        end
        host_req = 1'b1; host_addr = 12'd3000; host_data = 8'($urandom);
        #3;
        chk("s5/host_ack_same_cycle", host_ack, 1);
        @(posedge pixel_clk); #1;
        host_req = 1'b0;
        repeat (20) begin
            @(posedge pixel_clk); #1;
        end
        chk("s5/px_count", cap_px.size(), 0);
        chk("s5/tr_reads", cap_tr.size(), 0);
        chk("s5/fr_reads", cap_fr.size(), 0);
        chk("s5/line_done", done_cnt, 0);
        chk("s5/ram3000", ram[3000], host_data);

        // line_start and host_req together: fetch owns the port first.
        idx = 10'($urandom_range(0, 479));
        build_exp(idx);
        @(posedge pixel_clk); #1;
        clear_caps();
        line_start = 1'b1; line_idx = idx;
        host_req = 1'b1; host_addr = 12'd4000; host_data = 8'h5C;
        #3;
        chk("s6h/ack_blocked", host_ack, 0);
        chk("s6h/tr_addr_fetch", tr_addr, exp_tr[0]);
        @(posedge pixel_clk); #1;
        line_start = 1'b0;
        #3;
        chk("s6h/ack_next", host_ack, 1);
        @(posedge pixel_clk); #1;
        host_req = 1'b0;
        wait_done("s6h");
        check_line("s6h", 643);

        // Overrun: second line_start at px 400.
        idx   = 10'($urandom_range(0, 479));
        idx_b = 10'($urandom_range(0, 479));
        start_line(idx);
        wait_px("s6a", 400);
        chk("s6/no_done_before_abort", done_cnt, 0);
        build_exp(idx_b);
        start_line(idx_b);
        wait_done("s6");
        check_line("s6", 643);
        chk("s6/overrun_count", ovr_cnt, 1);

        // Reset mid-line, then a clean line.
        idx = 10'($urandom_range(0, 479));
        start_line(idx);
        wait_px("s1", 300);
        @(posedge pixel_clk); #1;
        rst = 1'b1;
        #3;
        chk_zero("s1_rst");
        repeat (2) @(posedge pixel_clk);
        #1;
        rst = 1'b0;
        idx = 10'($urandom_range(0, 479));
        build_exp(idx);
        start_line(idx);
        wait_done("s1");
        check_line("s1", 643);

        // Last visible line under random backpressure.
        build_exp(10'd479);
        start_line(10'd479);
        for (int i = 0; i < 4000 && done_cnt == 0; i++) begin
            @(posedge pixel_clk); #1;
            fifo_full = ($urandom_range(0, 3) == 0);
        end
        fifo_full = 1'b0;
        wait_done("s7");
        check_line("s7", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
